// File: rtl/uart_tx_target.sv
// Transmit-only UART responder on the minisoc req/addr_ok/data_ok bus: TX FIFO, divisor register, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames) and set STATUS[3].
module uart_tx_target #(
    parameter int          AW         = 16,
    parameter int          DW         = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            uart_req,
    input  logic            uart_write,
    input  logic [DW/8-1:0] uart_wstrb,
    input  logic [AW-1:0]   uart_addr,
    input  logic [DW-1:0]   uart_wdata,
    output logic            uart_addr_ok,
    output logic            uart_data_ok,
    output logic [DW-1:0]   uart_rdata,
    output logic            uart_txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [15:0]   div_q, div_d;
    logic          data_ok_q, data_ok_d;
    logic [DW-1:0] rdata_q, rdata_d;

    state_e        state_q, state_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [15:0]   baud_lim_q, baud_lim_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          txd_q, txd_d;

    // ------------------------------------------------------------------
    // Bus decode and handshake
    // ------------------------------------------------------------------
    reg_sel_e      reg_sel;
    logic          fifo_full;
    logic          fifo_empty;
    logic          stall;
    logic          accept;
    logic          push;
    logic          pop;
    logic          start_frame;
    logic          bit_end;
    logic [7:0]    fifo_head;
    logic [15:0]   status_w;

    assign reg_sel    = reg_sel_e'(uart_addr[3:2]);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // The stall looks only at the registered full flag, so a pop in the
    // same cycle does not open the slot until the following cycle.
    assign stall        = uart_write && (reg_sel == REG_TXDATA) && fifo_full;
    assign uart_addr_ok = uart_req && !stall;
    assign accept       = uart_addr_ok;
    assign push         = accept && uart_write && (reg_sel == REG_TXDATA) && uart_wstrb[0];

    always_comb begin
        status_w      = '0;
        status_w[0]   = fifo_full;
        status_w[1]   = fifo_empty;
        status_w[2]   = (state_q != S_IDLE);
`ifdef UART_TX_PARITY_EN
        status_w[3]   = 1'b1;
`endif
        status_w[15:8] = 8'(count_q);
    end

    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        div_d     = div_q;
        data_ok_d = accept;
        rdata_d   = '0;

        if (accept && uart_write && (reg_sel == REG_DIV)) begin
            if (uart_wstrb[0]) div_d[7:0]  = uart_wdata[7:0];
            if (uart_wstrb[1]) div_d[15:8] = uart_wdata[15:8];
        end

        if (accept && !uart_write) begin
            case (reg_sel)
                REG_STATUS: rdata_d[15:0] = status_w;
                REG_DIV:    rdata_d[15:0] = div_q;
                default:    rdata_d       = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: the storage array carries no reset; the pointers and count
    // are reset, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= uart_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    assign bit_end = (baud_cnt_q == baud_lim_q);

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        baud_lim_d  = baud_lim_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        txd_d       = txd_q;
        start_frame = 1'b0;

        // The limit is re-latched at every bit boundary, so a divisor
        // write mid-bit only affects the following bit.
        if (state_q != S_IDLE) begin
            if (bit_end) begin
                baud_cnt_d = '0;
                baud_lim_d = div_q;
            end else begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Back-to-back frames reload straight from STOP with no idle bit.
        if (start_frame) begin
            state_d    = S_START;
            shift_d    = fifo_head;
            parity_d   = ^fifo_head;
            txd_d      = 1'b0;
            baud_cnt_d = '0;
            baud_lim_d = div_q;
        end
    end

    assign pop = start_frame;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments
    // so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            div_q      <= DIV_RESET;
            data_ok_q  <= 1'b0;
            rdata_q    <= '0;
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            baud_lim_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            div_q      <= div_d;
            data_ok_q  <= data_ok_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            baud_lim_q <= baud_lim_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_data_ok = data_ok_q;
    assign uart_rdata   = rdata_q;
    assign uart_txd     = txd_q;

    // Bus bits this block never decodes.
    logic unused_bits;
`ifdef UART_TX_PARITY_EN
    assign unused_bits = ^{uart_addr[AW-1:4], uart_addr[1:0], uart_wdata[DW-1:16],
                           uart_wstrb[DW/8-1:2]};
`else
    assign unused_bits = ^{uart_addr[AW-1:4], uart_addr[1:0], uart_wdata[DW-1:16],
                           uart_wstrb[DW/8-1:2], parity_q};
`endif

endmodule
